// File: rtl/alu_pkg.sv
// alu_pkg: shared function codes and FSM state encoding for the serial ALU
package alu_pkg;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
endpackage

// File: rtl/alu_slice.sv
// alu_slice: one DIGIT-bit slice of the Y86 ALU, reused every cycle by the serial engine
module alu_slice
  import alu_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  input  logic [3:0]       fun_i,
  output logic [DIGIT-1:0] res_o,
  output logic             cout_o
);
  logic [DIGIT:0] sum;
  // sub computes b + ~a + cin so the result follows Y86 order (valB - valA); illegal codes yield zero
  always_comb begin
    sum = {1'b0, b_i} + {1'b0, (fun_i == ALU_SUB) ? ~a_i : a_i} + {{DIGIT{1'b0}}, cin_i};
    res_o = (fun_i == ALU_ADD || fun_i == ALU_SUB) ? sum[DIGIT-1:0] :
            (fun_i == ALU_AND) ? (a_i & b_i) :
            (fun_i == ALU_XOR) ? (a_i ^ b_i) : '0;
    cout_o = sum[DIGIT];
  end
endmodule

// File: rtl/serial_alu64.sv
// serial_alu64: slice-serial Y86 ALU, DIGIT bits per cycle LSB first, valid/ready on both sides
module serial_alu64
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] val_a,
  input  logic [WIDTH-1:0] val_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] val_e,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             bad_fun
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, val_e_q, val_e_d;
  logic [3:0]       fun_q, fun_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, zacc_q, zacc_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             zf_q, zf_d, sf_q, sf_d, of_q, of_d, bad_q, bad_d;
  logic [DIGIT-1:0] res;
  logic             cout, last;

  alu_slice #(.DIGIT(DIGIT)) u_slice (
    .a_i   (a_q[DIGIT-1:0]),
    .b_i   (b_q[DIGIT-1:0]),
    .cin_i (carry_q),
    .fun_i (fun_q),
    .res_o (res),
    .cout_o(cout)
  );

  assign last      = cnt_q == CW'(N - 1);
  assign in_ready  = state_q == S_IDLE;
  assign out_valid = state_q == S_DONE;
  assign val_e     = val_e_q;
  assign zf        = zf_q;
  assign sf        = sf_q;
  assign of        = of_q;
  assign bad_fun   = bad_q;

  // next state: latch on accept, shift one slice per RUN cycle, resolve flags on the final slice
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    fun_d   = fun_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    zacc_d  = zacc_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    val_e_d = val_e_q;
    zf_d    = zf_q;
    sf_d    = sf_q;
    of_d    = of_q;
    bad_d   = bad_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        a_d     = val_a;
        b_d     = val_b;
        fun_d   = ifun;
        carry_d = ifun == ALU_SUB;
        cnt_d   = '0;
        zacc_d  = 1'b1;
        a_msb_d = val_a[WIDTH-1];
        b_msb_d = val_b[WIDTH-1];
        state_d = S_RUN;
      end
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = cout;
        cnt_d   = cnt_q + CW'(1);
        zacc_d  = zacc_q & ~|res;
        val_e_d = {res, val_e_q[WIDTH-1:DIGIT]};
        if (last) begin
          state_d = S_DONE;
          zf_d    = zacc_q & ~|res;
          sf_d    = res[DIGIT-1];
          of_d    = (fun_q == ALU_ADD) ? (a_msb_q == b_msb_q) && (res[DIGIT-1] != a_msb_q) :
                    (fun_q == ALU_SUB) ? (a_msb_q != b_msb_q) && (res[DIGIT-1] != b_msb_q) : 1'b0;
          bad_d   = fun_q > ALU_XOR;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state register with synchronous reset to idle and cleared outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      fun_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      val_e_q <= '0;
      zf_q    <= 1'b0;
      sf_q    <= 1'b0;
      of_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fun_q   <= fun_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      zacc_q  <= zacc_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      val_e_q <= val_e_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      of_q    <= of_d;
      bad_q   <= bad_d;
    end
  end
endmodule

// File: tb/tb_serial_alu64.sv
// tb_serial_alu64: scoreboard bench for DIGIT=1 and DIGIT=8 instances against an arithmetic model
module tb_serial_alu64;
  localparam int W  = 64;
  localparam int CV = W + 4;
  typedef logic [CV-1:0] cv_t;
  typedef struct packed {logic [W-1:0] v; logic z, s, o, b;} res_t;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic [3:0] ifun = 0;
  logic [W-1:0] val_a = 0, val_b = 0;
  logic in_ready1, out_valid1, zf1, sf1, of1, bad1;
  logic in_ready8, out_valid8, zf8, sf8, of8, bad8;
  logic [W-1:0] val_e1, val_e8;
  int checks = 0, errors = 0;
  res_t q1[$], q8[$];
  int busy1 = 0, busy8 = 0;
  bit seen1 = 0, seen8 = 0;

  always #5 clk = ~clk;

  serial_alu64 #(.WIDTH(W), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .ifun(ifun),
    .val_a(val_a), .val_b(val_b), .out_valid(out_valid1), .out_ready(out_ready),
    .val_e(val_e1), .zf(zf1), .sf(sf1), .of(of1), .bad_fun(bad1));

  serial_alu64 #(.WIDTH(W), .DIGIT(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .ifun(ifun),
    .val_a(val_a), .val_b(val_b), .out_valid(out_valid8), .out_ready(out_ready),
    .val_e(val_e8), .zf(zf8), .sf(sf8), .of(of8), .bad_fun(bad8));

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f);
    res_t r;
    r = '0;
    case (f)
      4'd0: begin r.v = b + a; r.o = (a[W-1] == b[W-1]) && (r.v[W-1] != a[W-1]); end
      4'd1: begin r.v = b - a; r.o = (a[W-1] != b[W-1]) && (r.v[W-1] != b[W-1]); end
      4'd2: r.v = a & b;
      4'd3: r.v = a ^ b;
      default: r.b = 1'b1;
    endcase
    r.z = r.v == '0;
    r.s = r.v[W-1];
    return r;
  endfunction

  task automatic check(input string name, input cv_t act, input cv_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic spurious(input string name, input logic [W-1:0] v);
    checks++;
    errors++;
    $display("FAIL %s: result %h presented with no operation outstanding", name, v);
  endtask

  always begin
    @(negedge clk);
    #2;
    if (in_ready1) begin busy1 = 0; seen1 = 0; end
    else if (!out_valid1) busy1++;
    else begin
      if (!seen1) begin seen1 = 1; check("latency1", cv_t'(busy1), cv_t'(64)); end
      if (out_ready && !rst) begin
        if (q1.size() == 0) spurious("extra1", val_e1);
        else check("result1", {val_e1, zf1, sf1, of1, bad1}, q1.pop_front());
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (in_ready8) begin busy8 = 0; seen8 = 0; end
    else if (!out_valid8) busy8++;
    else begin
      if (!seen8) begin seen8 = 1; check("latency8", cv_t'(busy8), cv_t'(8)); end
      if (out_ready && !rst) begin
        if (q8.size() == 0) spurious("extra8", val_e8);
        else check("result8", {val_e8, zf8, sf8, of8, bad8}, q8.pop_front());
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f);
    int n = 0;
    @(negedge clk);
    while (!(in_ready1 && in_ready8) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL idle_timeout: in_ready %b/%b required 1/1", in_ready1, in_ready8);
    end
    val_a = a; val_b = b; ifun = f; in_valid = 1;
    q1.push_back(model(a, b, f));
    q8.push_back(model(a, b, f));
    @(negedge clk);
    in_valid = 0;
    val_a = {$urandom, $urandom};
    val_b = {$urandom, $urandom};
    ifun = 4'($urandom_range(0, 15));
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() != 0 || q8.size() != 0) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout: outstanding %0d/%0d required 0/0", q1.size(), q8.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra, rb;
    res_t hold;
    int n;
    repeat (3) @(negedge clk);
    check("reset_out1", cv_t'({val_e1, zf1, sf1, of1, bad1}), cv_t'(0));
    check("reset_hs1", cv_t'({in_ready1, out_valid1}), cv_t'(2'b10));
    check("reset_out8", cv_t'({val_e8, zf8, sf8, of8, bad8, in_ready8, out_valid8}), cv_t'(2'b10));
    rst = 0;
    issue(64'hB, 64'h4, 4'd3);
    issue(64'hB, 64'hC, 4'd3);
    issue(64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 4'd0);
    issue(64'hFFFF_FFFF_FFFF_FFFE, 64'd13, 4'd1);
    issue(64'hFFFF_FFFF_FFFF_FFF3, 64'hFFFF_FFFF_FFFF_FFFE, 4'd1);
    issue(64'd9, 64'd9, 4'd1);
    issue({$urandom, $urandom}, {$urandom, $urandom}, 4'd7);
    issue(64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0);
    issue(64'h1, 64'h8000_0000_0000_0000, 4'd1);
    drain();
    out_ready = 0;
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    hold = model(ra, rb, 4'd0);
    issue(ra, rb, 4'd0);
    n = 0;
    while (!out_valid1 && n < 200) begin @(negedge clk); n++; end
    check("bp_valid", cv_t'(out_valid1), cv_t'(1));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1;
      val_a = {$urandom, $urandom};
      val_b = {$urandom, $urandom};
      ifun = 4'd1;
      @(negedge clk);
      check("bp_hold1", {val_e1, zf1, sf1, of1, bad1}, hold);
      check("bp_hold8", {val_e8, zf8, sf8, of8, bad8}, hold);
      check("bp_ready", cv_t'({in_ready1, in_ready8, out_valid1, out_valid8}), cv_t'(4'b0011));
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    check("bp_release", cv_t'({in_ready1, in_ready8, out_valid1, out_valid8}), cv_t'(4'b1100));
    drain();
    issue({$urandom, $urandom}, {$urandom, $urandom}, 4'd0);
    repeat (29) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    q1.delete();
    check("midrst_hs", cv_t'({in_ready1, out_valid1}), cv_t'(2'b10));
    check("midrst_out", cv_t'({val_e1, zf1, sf1, of1, bad1}), cv_t'(0));
    issue(64'd2, 64'd3, 4'd0);
    drain();
    for (int i = 0; i < 24; i++) begin
      ra = {$urandom, $urandom};
      rb = (i % 5 == 0) ? ra : {$urandom, $urandom};
      issue(ra, rb, 4'($urandom_range(0, 9) > 7 ? $urandom_range(4, 15) : $urandom_range(0, 3)));
    end
    drain();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_alu64.md
Name: serial_alu64

Overview:
- Multi-cycle, slice-serial Y86 ALU. It is the sequential counterpart of the combinational 64-bit bitwise/arith units.
- Accepts one operation (valA, valB, ifun) through a valid/ready handshake.
- Processes DIGIT bits per cycle, LSB first, through a single slice datapath.
- Returns valE plus condition codes (ZF, SF, OF) through a valid/ready handshake.
- Sits beside the execute stage for area-reduced builds and as a cross-check engine for the combinational ALU.

Parameters:
- WIDTH, 64, operand/result width in bits.
- DIGIT, 1, bits processed per cycle. Must divide WIDTH; legal values 1, 2, 4, 8, 16.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept a request this cycle.
- ifun  input  4  Y86 OPq function code: 0 add, 1 sub, 2 and, 3 xor.
- val_a  input  WIDTH  operand A (valA).
- val_b  input  WIDTH  operand B (valB).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- val_e  output  WIDTH  result.
- zf  output  1  zero flag.
- sf  output  1  sign flag (val_e[WIDTH-1]).
- of  output  1  signed overflow flag.
- bad_fun  output  1  ifun was >3 for this result.

Behaviour:
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: in_ready=1, out_valid=0, val_e=0, zf=0, sf=0, of=0, bad_fun=0. Counter=0, carry=0.
- in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE, on in_valid=1:
  - Latch val_a, val_b and ifun into shift registers.
  - Carry init: 1 for sub, else 0.
  - Counter=0; go to RUN.
- RUN, each cycle processes slice k = counter (bits k*DIGIT .. k*DIGIT+DIGIT-1):
  - add: b + a + carry, with the carry propagated.
  - sub: b + ~a + carry, i.e. val_e = val_b - val_a (Y86 order).
  - and / xor: bitwise, carry ignored.
  - Result slice shifts into val_e from the MSB end. Operands shift right by DIGIT.
  - Running zero-accumulator is ANDed with (slice==0).
- RUN exit: at the edge where counter == WIDTH/DIGIT-1, go to DONE and set out_valid=1. Latency is WIDTH/DIGIT edges after the accept edge (64 for defaults).
- Flags, computed at the RUN exit edge:
  - zf = (val_e==0).
  - sf = val_e MSB.
  - of for add = (a_msb==b_msb) && (res_msb!=a_msb).
  - of for sub = (a_msb!=b_msb) && (res_msb!=b_msb).
  - of = 0 for and/xor.
  - Original operand MSBs are captured at accept.
- Illegal ifun (>3): still runs full latency. Result = 0, zf=1, sf=0, of=0, bad_fun=1.
- DONE: hold all outputs stable while out_ready=0. On out_valid && out_ready, go to IDLE; outputs keep their values, out_valid=0.
- No accept in the same cycle as a result handoff: in_ready stays 0 in DONE. Throughput is one op per WIDTH/DIGIT+2 cycles.
- in_valid in RUN/DONE is ignored, with no side effects. ifun/val_a/val_b changes after accept have no effect.
- rst overrides everything, including mid-RUN and in DONE with out_ready=1: next state IDLE, all outputs at reset values, partial result discarded.
- Arithmetic wraps modulo 2^WIDTH; the final carry is discarded.

Decomposition:
- Shared package (alu_pkg): ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_XOR=3 ifun constants; FSM state encoding typedef.
- One sub-module: alu_slice. Combinational DIGIT-bit slice taking a, b, cin, fun and producing res, cout. Instantiated once and reused every cycle.

Test Plan:
- xor: a=0xB, b=0x4 -> after 64 cycles val_e=0xF, zf=0, sf=0, of=0. Then a=0xB, b=0xC -> val_e=0x7.
- add overflow: a=1, b=0x7FFF_FFFF_FFFF_FFFF -> val_e=0x8000_0000_0000_0000, sf=1, of=1, zf=0.
- sub: a=-2, b=13 -> val_e=15. Then a=-13, b=-2 -> val_e=11, of=0. Then a=9, b=9 -> val_e=0, zf=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. val_e/flags stable, in_ready=0, second in_valid ignored. Release -> in_ready=1 the next cycle.
- Reset mid-op: assert rst at RUN cycle 30 -> next cycle in IDLE, out_valid=0, val_e=0. A new add 2+3 then yields 5 with normal latency.
- ifun=7: val_e=0, zf=1, bad_fun=1. Repeat with DIGIT=8: add latency is 8 cycles and results match DIGIT=1.
